// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding
// and the legal range of the pattern-width parameter.
package seq_detect_pkg;

   typedef enum logic [1:0] {
      UNCFG = 2'b00,
      HUNT  = 2'b01,
      ARMED = 2'b10
   } state_e;

   localparam int PAT_W_MIN = 2;
   localparam int PAT_W_MAX = 16;

   // True when a pattern width lies inside the supported range.
   function automatic bit pat_w_legal(input int w);
      return (w >= PAT_W_MIN) && (w <= PAT_W_MAX);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones, synchronous clear has priority
// over increment, asynchronous active-high reset.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;

   // Count up on inc, stick at all-ones, clear on clr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detect_fsm.sv
// Configurable serial sequence detector. Bits shift into a history register
// while en=1; y pulses one cycle after the bit that completes the pattern.
// Optional feature: define MATCH_CNT_EN to add the saturating match_cnt port.
module seq_detect_fsm
   import seq_detect_pkg::*;
#(
   parameter int PAT_W   = 8,
   parameter int OVERLAP = 1,
   parameter int CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         x,
   input  logic                         cfg_we,
   input  logic [PAT_W-1:0]             cfg_pattern,
   input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
   output logic                         y,
   output logic [1:0]                   state
`ifdef MATCH_CNT_EN
   ,
   output logic [CNT_W-1:0]             match_cnt
`endif
);

   localparam int LEN_W = $clog2(PAT_W + 1);
   localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
   // An out-of-range instance never accepts a configuration and stays idle.
   localparam bit PARAMS_LEGAL = pat_w_legal(PAT_W) && (CNT_W >= 1);

   state_e           state_q;
   logic [PAT_W-1:0] hist_q;
   logic [PAT_W-1:0] pat_q;
   logic [LEN_W-1:0] fill_q;
   logic [LEN_W-1:0] len_q;
   logic             y_q;

   logic [PAT_W-1:0] hist_d;
   logic [LEN_W-1:0] fill_d;
   logic             match_d;
   logic             cfg_ok;
   logic             shift_en;

   // Mask selecting the low l bits of the pattern/history.
   function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] l);
      logic [PAT_W-1:0] m;
      for (int i = 0; i < PAT_W; i++) begin
         m[i] = (LEN_W'(i) < l);
      end
      return m;
   endfunction

   // Next history/fill and match decision for the bit presented this cycle.
   always_comb begin
      cfg_ok   = PARAMS_LEGAL && cfg_we && (cfg_len != '0) && (cfg_len <= PAT_W_L);
      shift_en = en && ((state_q == HUNT) || (state_q == ARMED));
      hist_d   = {hist_q[PAT_W-2:0], x};
      fill_d   = (fill_q == PAT_W_L) ? fill_q : (fill_q + LEN_W'(1));
      match_d  = shift_en && (fill_d >= len_q) &&
                 (((hist_d ^ pat_q) & len_mask(len_q)) == '0);
   end

   // Detector FSM with registered match pulse; accepted config wins over data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= UNCFG;
         hist_q  <= '0;
         fill_q  <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         y_q     <= 1'b0;
      end else if (cfg_ok) begin
         pat_q   <= cfg_pattern;
         len_q   <= cfg_len;
         hist_q  <= '0;
         fill_q  <= '0;
         state_q <= HUNT;
         y_q     <= 1'b0;
      end else begin
         case (state_q)
            UNCFG: begin
               y_q <= 1'b0;
            end
            HUNT, ARMED: begin
               if (en) begin
                  hist_q <= hist_d;
                  y_q    <= match_d;
                  if (match_d && (OVERLAP == 0)) begin
                     fill_q  <= '0;
                     state_q <= HUNT;
                  end else begin
                     fill_q  <= fill_d;
                     state_q <= (fill_d >= len_q) ? ARMED : HUNT;
                  end
               end else begin
                  y_q <= 1'b0;
               end
            end
            default: begin
               state_q <= UNCFG;
               y_q     <= 1'b0;
            end
         endcase
      end
   end

   assign y     = y_q;
   assign state = state_q;

`ifdef MATCH_CNT_EN
   logic cnt_inc;

   // A match that is overridden by a same-cycle configuration is not counted.
   always_comb begin
      cnt_inc = match_d && !cfg_ok;
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (cnt_inc),
      .clr   (cfg_ok),
      .cnt_o (match_cnt)
   );
`endif

endmodule

// File: doc/seq_detect_fsm.md
SEQ_DETECT_FSM -- requirements
Module: seq_detect_fsm

Interface
REQ-001 SHALL have parameter PAT_W, 8, maximum pattern length in bits (legal range 2..16).
REQ-002 SHALL have parameter OVERLAP, 1, where 1 means overlapping matches and 0 means non-overlapping matches.
REQ-003 SHALL have parameter CNT_W, 8, match counter width.
REQ-004 SHALL have port clk, input, 1, clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port en, input, 1, serial bit valid; x is sampled only when en=1.
REQ-007 SHALL have port x, input, 1, serial data bit.
REQ-008 SHALL have port cfg_we, input, 1, single-cycle configuration write strobe.
REQ-009 SHALL have port cfg_pattern, input, PAT_W, pattern; cfg_pattern[len-1] is the first bit received.
REQ-010 SHALL have port cfg_len, input, $clog2(PAT_W+1), active pattern length.
REQ-011 SHALL have port y, output, 1, registered match pulse.
REQ-012 SHALL have port state, output, 2, current FSM state encoding.
REQ-013 SHALL have port match_cnt, output, CNT_W, saturating match count; present only with MATCH_CNT_EN.

Function
REQ-014 The FSM SHALL have states UNCFG=2'b00, HUNT=2'b01, ARMED=2'b10; encoding 2'b11 SHALL return to UNCFG on the next clock.
REQ-015 The block SHALL hold a PAT_W-bit history register, with the newest bit in history[0], and a fill counter saturating at PAT_W.
REQ-016 In UNCFG, x SHALL be ignored and y SHALL be 0.
REQ-017 A cfg_we with 1<=cfg_len<=PAT_W SHALL latch pattern and length, clear history and fill, and enter HUNT.
REQ-018 A cfg_we with cfg_len=0 or cfg_len>PAT_W SHALL be ignored; state, pattern and length SHALL be unchanged.
REQ-019 If cfg_we and en are high in the same cycle, the configuration SHALL take effect and that x bit SHALL be discarded.
REQ-020 In HUNT or ARMED with en=1, x SHALL shift into history and fill SHALL increment.
REQ-021 The FSM SHALL move HUNT->ARMED when fill reaches len.
REQ-022 A match SHALL be history[len-1:0] equal to pattern[len-1:0] after the shift while fill>=len.
REQ-023 On a match, y SHALL be 1 for exactly one cycle, in the cycle after the completing bit's edge (latency 1).
REQ-024 With OVERLAP=1, history and fill SHALL be kept after a match and the FSM SHALL stay in ARMED.
REQ-025 With OVERLAP=0, fill SHALL clear after a match and the FSM SHALL return to HUNT, so the next match needs len fresh bits.
REQ-026 With en=0, history, fill and state SHALL hold, and y SHALL be 0 in the following cycle.
REQ-027 When en is held high, y SHALL be able to assert on consecutive cycles (for example pattern 11 on input 111).

Reset
REQ-028 rst SHALL set state to UNCFG and clear history, fill, pattern, length, y and match_cnt to 0.
REQ-029 Reset asserted mid-stream SHALL discard all partial history; no y pulse SHALL follow reset release until a new cfg_we.

Configuration
REQ-030 With macro MATCH_CNT_EN defined, match_cnt SHALL increment on each match, saturate at all-ones, and clear on an accepted cfg_we.
REQ-031 Without MATCH_CNT_EN, the match_cnt port and its counter logic SHALL be absent.

Structure
REQ-032 The state encoding typedef (UNCFG/HUNT/ARMED) and the PAT_W legal-range constants SHALL reside in shared package seq_detect_pkg.
REQ-033 The saturating counter SHALL be sub-module sat_counter, parametrised by width, with inputs inc and clr.

Verification
REQ-034 PAT_W=8, OVERLAP=1, pattern 1011 with len 4, stream 1,0,1,1,0,1,1 with en=1 -> y pulses after bits 4 and 7; match_cnt=2.
REQ-035 Same stream with OVERLAP=0 -> y pulses after bit 4 only; match_cnt=1.
REQ-036 cfg_we with cfg_len=0 or cfg_len=9 -> ignored; state, pattern and y unchanged.
REQ-037 cfg_we concurrent with en=1 and x=1 -> bit discarded; fill=0; state=HUNT.
REQ-038 rst pulsed after 3 of 4 pattern bits -> state=UNCFG, y=0, and no pulse after further bits until reconfigured.
REQ-039 MATCH_CNT_EN with CNT_W=2, pattern 11 with len 2, input 1 x6 (OVERLAP=1) -> y pulses 5 times; match_cnt saturates at 3.
